// File: rtl/remap_accel_hls_deadlock_report_unit_if.sv
// remap_accel_hls_deadlock_report_unit_if: detect-unit side bus of the deadlock report unit.
interface remap_accel_hls_deadlock_report_unit_if #(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = 2
);
  logic [PROC_NUM-1:0] dl_in_vec;
  logic                dl_detect_global;
  logic [PROC_NUM-1:0] origin_vec;
  logic [PROC_NUM-1:0] token_clear_vec;
  logic                deadlock;
  logic [IDX_W-1:0]    dl_origin_idx;
  logic [PROC_NUM-1:0] dl_proc_mask;
  logic [IDX_W:0]      dl_loop_len;
  logic                report_vld;
  modport master (
    output dl_in_vec,
    input  dl_detect_global, origin_vec, token_clear_vec, deadlock,
    input  dl_origin_idx, dl_proc_mask, dl_loop_len, report_vld
  );
  modport slave (
    input  dl_in_vec,
    output dl_detect_global, origin_vec, token_clear_vec, deadlock,
    output dl_origin_idx, dl_proc_mask, dl_loop_len, report_vld
  );
endinterface

// File: rtl/remap_accel_hls_deadlock_report_unit.sv
// remap_accel_hls_deadlock_report_unit: arbitrates a deadlock origin, tracks the token walk, latches a sticky report.
module remap_accel_hls_deadlock_report_unit #(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = 2,
  parameter int TIMEOUT  = 64
) (
  input logic clock,
  input logic reset,
  remap_accel_hls_deadlock_report_unit_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = IDX_W + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0, ORIGIN = 2'd1, WALK = 2'd2, REPORT = 2'd3;
  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    origin_idx_q, origin_idx_d, rep_idx_q, rep_idx_d, low;
  logic [PROC_NUM-1:0] mask_q, mask_d, rep_mask_q, rep_mask_d, origin_vec_q, origin_vec_d, tc;
  logic [CW-1:0]       cnt_q, cnt_d, rep_len_q, rep_len_d, add;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                global_q, global_d, deadlock_q, deadlock_d, rv_q, rv_d, publish;
  always_comb begin
    low = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) if (bus.dl_in_vec[i]) low = IDX_W'(i);
    add = '0;
    for (int j = 0; j < PROC_NUM; j++) add = add + CW'(bus.dl_in_vec[j] & ~mask_q[j]);
    state_d = state_q;
    origin_idx_d = origin_idx_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    tc = '0;
    case (state_q)
      IDLE: if (|bus.dl_in_vec) begin
        origin_idx_d = low;
        state_d = ORIGIN;
      end
      ORIGIN: begin
        mask_d = '0;
        cnt_d = '0;
        tmo_d = TMO_LOAD;
        state_d = WALK;
      end
      WALK: begin
        mask_d = mask_q | bus.dl_in_vec;
        cnt_d = cnt_q + add;
        if (bus.dl_in_vec[origin_idx_q]) begin
          tc = PROC_NUM'(1) << origin_idx_q;
          state_d = REPORT;
        end else if (|bus.dl_in_vec) tmo_d = TMO_LOAD;
        else begin
          tmo_d = tmo_q - 1'b1;
          state_d = (tmo_q == '0) ? IDLE : WALK;
        end
      end
      default: ;
    endcase
    publish = (state_q == WALK) && (state_d == REPORT);
    global_d = state_d != IDLE;
    origin_vec_d = (state_d == ORIGIN) ? PROC_NUM'(1) << origin_idx_d : '0;
    deadlock_d = deadlock_q | publish;
    rv_d = publish;
    rep_idx_d = publish ? origin_idx_q : rep_idx_q;
    rep_mask_d = publish ? mask_d : rep_mask_q;
    rep_len_d = publish ? cnt_d : rep_len_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      origin_idx_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      global_q <= 1'b0;
      origin_vec_q <= '0;
      deadlock_q <= 1'b0;
      rv_q <= 1'b0;
      rep_idx_q <= '0;
      rep_mask_q <= '0;
      rep_len_q <= '0;
    end else begin
      state_q <= state_d;
      origin_idx_q <= origin_idx_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      global_q <= global_d;
      origin_vec_q <= origin_vec_d;
      deadlock_q <= deadlock_d;
      rv_q <= rv_d;
      rep_idx_q <= rep_idx_d;
      rep_mask_q <= rep_mask_d;
      rep_len_q <= rep_len_d;
    end
  end
  assign bus.dl_detect_global = global_q;
  assign bus.origin_vec = origin_vec_q;
  assign bus.token_clear_vec = tc;
  assign bus.deadlock = deadlock_q;
  assign bus.dl_origin_idx = rep_idx_q;
  assign bus.dl_proc_mask = rep_mask_q;
  assign bus.dl_loop_len = rep_len_q;
  assign bus.report_vld = rv_q;
endmodule

// File: tb/tb_remap_accel_hls_deadlock_report_unit.sv
// tb_remap_accel_hls_deadlock_report_unit: directed and random token-walk scenarios against a queue-based loop model.
module tb_remap_accel_hls_deadlock_report_unit;
  localparam int N = 4;
  localparam int TMO = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0, failures = 0;
  remap_accel_hls_deadlock_report_unit_if #(.PROC_NUM(N), .IDX_W(2)) bus ();
  remap_accel_hls_deadlock_report_unit #(.PROC_NUM(N), .IDX_W(2), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  // Model: alarm active / origin cycle pending / loop closed, plus the ordered list of token holders.
  bit m_act, m_first, m_done, e_rv;
  int m_org, m_idle, r_org, r_len;
  int seen[$];
  logic [N-1:0] e_origin, r_mask;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    m_act = 0; m_first = 0; m_done = 0; e_rv = 0; m_org = 0; m_idle = 0;
    r_org = 0; r_len = 0; r_mask = '0; e_origin = '0; seen.delete();
  endtask
  function automatic logic [N-1:0] exp_tc();
    logic [N-1:0] x = bus.dl_in_vec;
    return (m_act && !m_first && !m_done && x[m_org]) ? N'(1 << m_org) : '0;
  endfunction
  task automatic check_outs(input string tag);
    chk({tag, ".global"}, 32'(bus.dl_detect_global), 32'(m_act));
    chk({tag, ".origin"}, 32'(bus.origin_vec), 32'(e_origin));
    chk({tag, ".tclr"}, 32'(bus.token_clear_vec), 32'(exp_tc()));
    chk({tag, ".deadlock"}, 32'(bus.deadlock), 32'(m_done));
    chk({tag, ".rvld"}, 32'(bus.report_vld), 32'(e_rv));
    chk({tag, ".idx"}, 32'(bus.dl_origin_idx), 32'(m_done ? r_org : 0));
    chk({tag, ".mask"}, 32'(bus.dl_proc_mask), 32'(m_done ? r_mask : '0));
    chk({tag, ".len"}, 32'(bus.dl_loop_len), 32'(m_done ? r_len : 0));
  endtask
  task automatic model_edge(input logic [N-1:0] x);
    bit found;
    e_origin = '0;
    e_rv = 0;
    if (!m_act) begin
      if (x != 0) begin
        for (int i = N - 1; i >= 0; i--) if (x[i]) m_org = i;
        m_act = 1; m_first = 1; e_origin = N'(1 << m_org);
      end
    end else if (m_first) begin
      m_first = 0; m_idle = 0; seen.delete();
    end else if (!m_done) begin
      for (int j = 0; j < N; j++) if (x[j]) begin
        found = 0;
        foreach (seen[k]) if (seen[k] == j) found = 1;
        if (!found) seen.push_back(j);
      end
      if (x[m_org]) begin
        m_done = 1; e_rv = 1; r_org = m_org; r_len = seen.size(); r_mask = '0;
        foreach (seen[k]) r_mask[seen[k]] = 1'b1;
      end else if (x != 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TMO) m_act = 0;
      end
    end
  endtask
  task automatic step(input logic [N-1:0] x, input string tag);
    @(negedge clock);
    bus.dl_in_vec = x;
    #1 chk({tag, ".tclr_comb"}, 32'(bus.token_clear_vec), 32'(exp_tc()));
    @(posedge clock);
    model_edge(x);
    #1 check_outs(tag);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.dl_in_vec = '0;
    model_clear();
    #1 check_outs("rst");
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask
  initial begin
    bus.dl_in_vec = '0;
    model_clear();
    do_reset();
    repeat (100) step(4'b0000, "quiet");
    step(4'b0110, "arb");
    chk("arb.origin_vec", 32'(bus.origin_vec), 32'h2);
    step(4'b0000, "org");
    step(4'b1000, "walk");
    step(4'b0010, "close");
    chk("loop.mask", 32'(bus.dl_proc_mask), 32'hA);
    chk("loop.len", 32'(bus.dl_loop_len), 32'd2);
    chk("loop.rvld", 32'(bus.report_vld), 32'd1);
    step(4'b0000, "hold");
    chk("loop.rvld_pulse", 32'(bus.report_vld), 32'd0);
    do_reset();
    step(4'b0001, "to.req");
    step(4'b0000, "to.org");
    repeat (TMO) step(4'b0000, "to.wait");
    chk("to.global", 32'(bus.dl_detect_global), 32'd0);
    step(4'b0001, "to.reissue");
    chk("to.reissue_vec", 32'(bus.origin_vec), 32'h1);
    do_reset();
    step(4'b0100, "sim.req");
    step(4'b0000, "sim.org");
    @(negedge clock);
    bus.dl_in_vec = 4'b0101;
    #1 chk("sim.tclr", 32'(bus.token_clear_vec), 32'h4);
    @(posedge clock);
    model_edge(4'b0101);
    #1 check_outs("sim");
    chk("sim.mask", 32'(bus.dl_proc_mask), 32'h5);
    for (int c = 0; c < 50; c++) step(N'($urandom), "rep");
    chk("rep.mask_held", 32'(bus.dl_proc_mask), 32'h5);
    do_reset();
    step(4'b0010, "ar.req");
    step(4'b0000, "ar.org");
    step(4'b1000, "ar.walk");
    #3 reset = 1'b0;
    model_clear();
    #1 check_outs("ar.async");
    @(negedge clock);
    bus.dl_in_vec = '0;
    @(negedge clock);
    reset = 1'b1;
    step(4'b0001, "ar.req2");
    chk("ar.origin_vec", 32'(bus.origin_vec), 32'h1);
    for (int r = 0; r < 15; r++) begin
      do_reset();
      for (int c = 0; c < 80; c++)
        step(($urandom_range(0, 3) == 0) ? N'($urandom) : '0, "rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
